// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one external combinational ALU; one operation in flight.
// Define ALU_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority to port 0.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_ctrl,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic [3:0]  rsp0_flags,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic [3:0]  rsp1_flags,
  output logic        rsp1_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags
);

  localparam int DATA_W = 32;
  localparam int CTRL_W = 3;
  localparam int FLAG_W = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [CTRL_W-1:0] op_ctrl_q, op_ctrl_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] res0_q, res0_d, res1_q, res1_d;
  logic [FLAG_W-1:0] flg0_q, flg0_d, flg1_q, flg1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic              vld0_q, vld0_d, vld1_q, vld1_d;
`ifdef ALU_ARB_RR_EN
  logic              prio_q, prio_d;
`endif

  logic              grant, grant_idx, rsp_take;
  logic [DATA_W-1:0] cap_res;
  logic [FLAG_W-1:0] cap_flg;
  logic              cap_err;

  function automatic logic ctrl_illegal(input logic [CTRL_W-1:0] c);
    return c[2] & c[1];
  endfunction

  always_comb begin
`ifdef ALU_ARB_RR_EN
    grant_idx = (req0_valid & req1_valid) ? prio_q : ~req0_valid;
`else
    grant_idx = ~req0_valid;
`endif
    grant = (req0_valid | req1_valid) & (state_q == IDLE);
  end

  // Ready is gated by reset so nothing handshakes while reset is held.
  assign req0_ready = reset & grant & ~grant_idx;
  assign req1_ready = reset & grant & grant_idx;

  always_comb begin
    if (ctrl_illegal(op_ctrl_q)) begin
      cap_res = '0;
      cap_flg = '0;
      cap_err = 1'b1;
    end else begin
      cap_res = alu_result;
      cap_flg = alu_flags;
      cap_err = 1'b0;
    end
    rsp_take = owner_q ? rsp1_ready : rsp0_ready;
  end

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_ctrl_d = op_ctrl_q;
    owner_d   = owner_q;
    res0_d    = res0_q;
    res1_d    = res1_q;
    flg0_d    = flg0_q;
    flg1_d    = flg1_q;
    err0_d    = err0_q;
    err1_d    = err1_q;
    vld0_d    = vld0_q;
    vld1_d    = vld1_q;
`ifdef ALU_ARB_RR_EN
    prio_d    = prio_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant) begin
          op_a_d    = grant_idx ? req1_a : req0_a;
          op_b_d    = grant_idx ? req1_b : req0_b;
          op_ctrl_d = grant_idx ? req1_ctrl : req0_ctrl;
          owner_d   = grant_idx;
`ifdef ALU_ARB_RR_EN
          prio_d    = ~grant_idx;
`endif
          state_d   = EXEC;
        end
      end
      EXEC: begin
        if (owner_q) begin
          res1_d = cap_res;
          flg1_d = cap_flg;
          err1_d = cap_err;
          vld1_d = 1'b1;
        end else begin
          res0_d = cap_res;
          flg0_d = cap_flg;
          err0_d = cap_err;
          vld0_d = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_take) begin
          vld0_d  = 1'b0;
          vld1_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_ctrl_q <= '0;
      owner_q   <= 1'b0;
      res0_q    <= '0;
      res1_q    <= '0;
      flg0_q    <= '0;
      flg1_q    <= '0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      vld0_q    <= 1'b0;
      vld1_q    <= 1'b0;
`ifdef ALU_ARB_RR_EN
      prio_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_ctrl_q <= op_ctrl_d;
      owner_q   <= owner_d;
      res0_q    <= res0_d;
      res1_q    <= res1_d;
      flg0_q    <= flg0_d;
      flg1_q    <= flg1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      vld0_q    <= vld0_d;
      vld1_q    <= vld1_d;
`ifdef ALU_ARB_RR_EN
      prio_q    <= prio_d;
`endif
    end
  end

  assign alu_a       = op_a_q;
  assign alu_b       = op_b_q;
  assign alu_ctrl    = op_ctrl_q;
  assign rsp0_valid  = vld0_q;
  assign rsp0_result = res0_q;
  assign rsp0_flags  = flg0_q;
  assign rsp0_err    = err0_q;
  assign rsp1_valid  = vld1_q;
  assign rsp1_result = res1_q;
  assign rsp1_flags  = flg1_q;
  assign rsp1_err    = err1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model plus directed vectors; honours ALU_ARB_RR_EN.
module tb_alu_arbiter;

  logic        clk, reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic        rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
  logic [31:0] rsp0_result, rsp1_result;
  logic [3:0]  rsp0_flags, rsp1_flags;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic [3:0]  alu_flags;

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_flags(alu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU {flags[3:0]={N,Z,C,V}, result[31:0]}; illegal codes return garbage on purpose.
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    logic [32:0] w;
    logic [31:0] r;
    logic        cy, v;
    cy = 1'b0;
    v  = 1'b0;
    w  = '0;
    case (c)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; cy = w[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; r = w[31:0]; cy = w[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a * b;
      default: return {4'b1111, a ^ b ^ 32'hDEADBEEF};
    endcase
    return {r[31], r == 32'd0, cy, v, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(alu_a, alu_b, alu_ctrl);

  // Transaction model: at most one accepted op, answered the cycle after acceptance.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_port = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [2:0]  m_c = '0;
  logic [31:0] m_res [2] = '{default: '0};
  logic [3:0]  m_flg [2] = '{default: '0};
  logic        m_err [2] = '{default: 1'b0};
  logic        m_vld [2] = '{default: 1'b0};
`ifdef ALU_ARB_RR_EN
  logic        m_prio = 1'b0;
`endif
  logic [35:0] m_alu;
  assign m_alu = alu_fn(m_a, m_b, m_c);

  function automatic int pick();
`ifdef ALU_ARB_RR_EN
    if (req0_valid && req1_valid) return m_prio ? 1 : 0;
`endif
    return req0_valid ? 0 : 1;
  endfunction

  function automatic logic exp_ready(input int p);
    if (!reset || m_busy || !(req0_valid || req1_valid)) return 1'b0;
    return pick() == p;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_port <= 1'b0;
      m_a <= '0; m_b <= '0; m_c <= '0;
      for (int i = 0; i < 2; i++) begin
        m_res[i] <= '0; m_flg[i] <= '0; m_err[i] <= 1'b0; m_vld[i] <= 1'b0;
      end
`ifdef ALU_ARB_RR_EN
      m_prio <= 1'b0;
`endif
    end else if (m_busy && !m_done) begin
      if (m_c > 3'd5) begin
        m_res[m_port] <= '0; m_flg[m_port] <= '0; m_err[m_port] <= 1'b1;
      end else begin
        m_res[m_port] <= m_alu[31:0]; m_flg[m_port] <= m_alu[35:32]; m_err[m_port] <= 1'b0;
      end
      m_vld[m_port] <= 1'b1;
      m_done <= 1'b1;
    end else if (m_busy) begin
      if (m_port ? rsp1_ready : rsp0_ready) begin
        m_vld[m_port] <= 1'b0;
        m_busy <= 1'b0;
      end
    end else if (req0_valid || req1_valid) begin
      if (pick() == 0) begin
        m_port <= 1'b0; m_a <= req0_a; m_b <= req0_b; m_c <= req0_ctrl;
      end else begin
        m_port <= 1'b1; m_a <= req1_a; m_b <= req1_b; m_c <= req1_ctrl;
      end
`ifdef ALU_ARB_RR_EN
      m_prio <= (pick() == 0);
`endif
      m_busy <= 1'b1;
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("req0_ready", 32'(req0_ready), 32'(exp_ready(0)));
    chk("req1_ready", 32'(req1_ready), 32'(exp_ready(1)));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(m_vld[0]));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(m_vld[1]));
    chk("rsp0_result", rsp0_result, m_res[0]);
    chk("rsp1_result", rsp1_result, m_res[1]);
    chk("rsp0_flags", 32'(rsp0_flags), 32'(m_flg[0]));
    chk("rsp1_flags", 32'(rsp1_flags), 32'(m_flg[1]));
    chk("rsp0_err", 32'(rsp0_err), 32'(m_err[0]));
    chk("rsp1_err", 32'(rsp1_err), 32'(m_err[1]));
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_ctrl", 32'(alu_ctrl), 32'(m_c));
  endtask

  always @(negedge clk) compare_model();

  // One uncontested operation on port p with rsp_ready high; DUT must be idle on entry.
  task automatic run_op(input logic p, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                        input logic [31:0] er, input logic [3:0] ef, input logic ee);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    if (p) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = c; end
    else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = c; end
    #1;
    chk("op_ready_idle", 32'(p ? req1_ready : req0_ready), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("op_ready_exec", 32'(req0_ready | req1_ready), 32'd0);
    @(posedge clk); #1;
    chk("op_rsp_valid", 32'(p ? rsp1_valid : rsp0_valid), 32'd1);
    chk("op_other_valid", 32'(p ? rsp0_valid : rsp1_valid), 32'd0);
    chk("op_result", p ? rsp1_result : rsp0_result, er);
    chk("op_flags", 32'(p ? rsp1_flags : rsp0_flags), 32'(ef));
    chk("op_err", 32'(p ? rsp1_err : rsp0_err), 32'(ee));
    @(posedge clk); #1;
    chk("op_rsp_consumed", 32'(p ? rsp1_valid : rsp0_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int g [4];
    int exp_g [4];
    int n_g;
`ifdef ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    g = '{default: -1};
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    #7;
    chk("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("reset_rsp0_result", rsp0_result, 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;

    run_op(1'b0, 32'd5, 32'd3, 3'b000, 32'h0000_0008, 4'b0000, 1'b0);
    run_op(1'b1, 32'd3, 32'd5, 3'b001, 32'hFFFF_FFFE, 4'b1000, 1'b0);
    run_op(1'b0, 32'd7, 32'd9, 3'b110, 32'h0000_0000, 4'b0000, 1'b1);
    chk("hold_rsp1_result", rsp1_result, 32'hFFFF_FFFE);
    chk("hold_rsp1_valid", 32'(rsp1_valid), 32'd0);
    run_op(1'b1, 32'hFF00_FF00, 32'h0F0F_0F0F, 3'b100, 32'hF00F_F00F, 4'b1000, 1'b0);
    run_op(1'b0, 32'd0, 32'd0, 3'b011, 32'h0000_0000, 4'b0100, 1'b0);
    run_op(1'b1, 32'd6, 32'd7, 3'b101, 32'd42, 4'b0000, 1'b0);
    run_op(1'b0, 32'h7FFF_FFFF, 32'd1, 3'b000, 32'h8000_0000, 4'b1001, 1'b0);
    run_op(1'b1, 32'd0, 32'd0, 3'b111, 32'h0000_0000, 4'b0000, 1'b1);

    // Response held back for four cycles while both requesters keep asking.
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h0000_F0F0; req0_b = 32'h0000_0FF0; req0_ctrl = 3'b010;
    #1;
    chk("stall_grant0", 32'(req0_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_ctrl = 3'b000;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("stall_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("stall_rsp0_result", rsp0_result, 32'h0000_00F0);
      chk("stall_rsp0_flags", 32'(rsp0_flags), 32'd0);
      chk("stall_ready0", 32'(req0_ready), 32'd0);
      chk("stall_ready1", 32'(req1_ready), 32'd0);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release", 32'(rsp0_valid), 32'd0);

    // Reset in the middle of an operation.
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = 3'b000;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_rsp1_result", rsp1_result, 32'd0);
    chk("rst_rsp0_result", rsp0_result, 32'd0);
    chk("rst_rsp1_err", 32'(rsp1_err), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    compare_model();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", 32'(rsp0_valid | rsp1_valid), 32'd0);
    end

    // Contested stream: both requesters valid continuously.
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'h7FFF_FFFF; req0_b = 32'd1; req0_ctrl = 3'b000;
    req1_valid = 1'b1; req1_a = 32'h0000_1234; req1_b = 32'h10; req1_ctrl = 3'b101;
    n_g = 0;
    for (int cyc = 0; cyc < 30 && n_g < 4; cyc++) begin
      #1;
      if (req0_ready || req1_ready) begin
        g[n_g] = req1_ready ? 1 : 0;
        n_g++;
      end
      @(posedge clk);
    end
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("grant_count", 32'(n_g), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("grant_%0d", i), 32'(g[i]), 32'(exp_g[i]));
    repeat (4) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
